// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// FSM state encodings and the all-zero word.
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between issue/writeback (master) and the register file (slave).
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) ();

  logic [NWRITE-1:0]        we;
  logic [NWRITE*ADDR_W-1:0] waddr;
  logic [NWRITE*DATA_W-1:0] wdata;
  logic [NREAD-1:0]         re;
  logic [NREAD*ADDR_W-1:0]  raddr;
  logic [NREAD*DATA_W-1:0]  rdata;
  logic [NREAD-1:0]         rbusy;
  logic                     bset;
  logic [ADDR_W-1:0]        bset_addr;
  logic                     clr_req;
  logic                     init_done;

  modport master (
    output we, waddr, wdata, re, raddr, bset, bset_addr, clr_req,
    input  rdata, rbusy, init_done
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, bset, bset_addr, clr_req,
    output rdata, rbusy, init_done
  );

endinterface

// File: rtl/regfile_mp_bypass_sel.sv
// Priority mux for one read port: finds the highest-index write port
// targeting the read address this cycle and forwards its data.
module regfile_bypass_sel
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NWRITE = 2
) (
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // Ascending scan so a later (higher-index) match overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < NWRITE; i++) begin
      if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
        hit  = 1'b1;
        data = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass, a busy scoreboard
// for issue, and a sequencer that sweeps storage to zero after reset/clear.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_if.slave   rf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic                run;
  logic [NREAD-1:0]    hit;
  logic [DATA_W-1:0]   byp_data [NREAD];

  assign run          = (state_q == ST_RUN);
  assign rf.init_done = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (ptr == LAST_ADDR) state_d = ST_RUN;
      ST_RUN:   if (rf.clr_req)       state_d = ST_CLEAR;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // The sweep pointer wraps from DEPTH-1 back to 0, so it is already
  // at zero whenever a clear request restarts the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr <= '0;
    else if (state_q == ST_CLEAR) ptr <= ptr + 1'b1;
    else if (rf.clr_req)       ptr <= '0;
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      regs[ptr] <= '0;
    end else begin
      for (int i = 0; i < NWRITE; i++) begin
        if (rf.we[i] && !(ZR && rf.waddr[i*ADDR_W +: ADDR_W] == '0))
          regs[rf.waddr[i*ADDR_W +: ADDR_W]] <= rf.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writeback clears are applied first so a same-cycle bset wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (state_q == ST_CLEAR || rf.clr_req) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NWRITE; i++) begin
        if (rf.we[i]) busy[rf.waddr[i*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      if (rf.bset && !(ZR && rf.bset_addr == '0))
        busy[rf.bset_addr] <= 1'b1;
    end
  end

  for (genvar j = 0; j < NREAD; j++) begin : g_byp
    regfile_bypass_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NWRITE (NWRITE)
    ) u_sel (
      .we    (rf.we),
      .waddr (rf.waddr),
      .wdata (rf.wdata),
      .raddr (rf.raddr[j*ADDR_W +: ADDR_W]),
      .hit   (hit[j]),
      .data  (byp_data[j])
    );
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra       = '0;
    rf.rdata = '0;
    rf.rbusy = '0;
    if (run) begin
      for (int j = 0; j < NREAD; j++) begin
        ra = rf.raddr[j*ADDR_W +: ADDR_W];
        if (rf.re[j] && !(ZR && ra == '0)) begin
          rf.rdata[j*DATA_W +: DATA_W] = hit[j] ? byp_data[j] : regs[ra];
          rf.rbusy[j] = busy[ra] & ~hit[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DEPTH=32, two read/two write ports).
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;
  int   test_count;
  int   fail_count;
  int   n;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(2), .NWRITE(2)) rf_bus ();

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(2), .NWRITE(2), .ZERO_REG(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic [1:0]  we,
    input logic [4:0]  wa0, input logic [31:0] wd0,
    input logic [4:0]  wa1, input logic [31:0] wd1,
    input logic [1:0]  re,
    input logic [4:0]  ra0, input logic [4:0] ra1,
    input logic        bs,  input logic [4:0] ba
  );
    rf_bus.we        = we;
    rf_bus.waddr     = {wa1, wa0};
    rf_bus.wdata     = {wd1, wd0};
    rf_bus.re        = re;
    rf_bus.raddr     = {ra1, ra0};
    rf_bus.bset      = bs;
    rf_bus.bset_addr = ba;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until init_done rises; optionally pulses clr_req mid-sweep.
  task automatic countSweep(input bit poke_clr, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
      if (poke_clr && cycles == 3) rf_bus.clr_req = 1'b1;
      if (cycles == 6) rf_bus.clr_req = 1'b0;
    end while (!rf_bus.init_done && cycles < 100);
    rf_bus.clr_req = 1'b0;
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    rst_n = 1'b0;
    rf_bus.clr_req = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd6, 1'b0, 5'd0);
    checkOutput("rst_init_done", 64'(rf_bus.init_done), 64'd0);
    checkOutput("rst_rbusy", 64'(rf_bus.rbusy), 64'd0);
    checkOutput("rst_rdata", 64'(rf_bus.rdata), 64'd0);
    tick();
    tick();

    // Release reset while hammering writes and bset that must be ignored.
    rst_n = 1'b1;
    applyStimulus(2'b01, 5'd5, 32'h77, 5'd0, 32'h0, 2'b11, 5'd5, 5'd6, 1'b1, 5'd6);
    tick();
    checkOutput("clear_rdata", 64'(rf_bus.rdata), 64'd0);
    checkOutput("clear_rbusy", 64'(rf_bus.rbusy), 64'd0);
    countSweep(1'b0, n);
    checkOutput("init_len", 64'(n + 1), 64'd32);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd6, 1'b0, 5'd0);
    checkOutput("x5_after_clear", 64'(rf_bus.rdata[31:0]), 64'd0);
    checkOutput("x6_not_busy", 64'(rf_bus.rbusy[1]), 64'd0);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'(a), 5'd0, 1'b0, 5'd0);
      checkOutput("init_zero", 64'(rf_bus.rdata[31:0]), 64'd0);
    end

    // Both ports write x3: port 1 wins both in bypass and in storage.
    applyStimulus(2'b11, 5'd3, 32'h11, 5'd3, 32'h22, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0);
    checkOutput("byp_prio", 64'(rf_bus.rdata[31:0]), 64'h22);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd3, 1'b0, 5'd0);
    checkOutput("x3_store0", 64'(rf_bus.rdata[31:0]), 64'h22);
    checkOutput("x3_store1", 64'(rf_bus.rdata[63:32]), 64'h22);
    applyStimulus(2'b11, 5'd10, 32'hA0, 5'd11, 32'hB1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd10, 5'd11, 1'b0, 5'd0);
    checkOutput("x10", 64'(rf_bus.rdata[31:0]), 64'hA0);
    checkOutput("x11", 64'(rf_bus.rdata[63:32]), 64'hB1);

    // Register zero: writes dropped, bypass suppressed, bset ignored.
    applyStimulus(2'b01, 5'd0, 32'hDEAD, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0);
    checkOutput("x0_bypass", 64'(rf_bus.rdata), 64'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0);
    checkOutput("x0_store", 64'(rf_bus.rdata), 64'd0);
    checkOutput("x0_busy", 64'(rf_bus.rbusy), 64'd0);

    // Busy set, then hidden by a same-cycle writeback, then cleared.
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd7);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd7, 1'b0, 5'd0);
    checkOutput("x7_busy", 64'(rf_bus.rbusy), 64'b01);
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd7, 32'h55, 2'b01, 5'd7, 5'd7, 1'b0, 5'd0);
    checkOutput("x7_byp_data", 64'(rf_bus.rdata[31:0]), 64'h55);
    checkOutput("x7_byp_busy", 64'(rf_bus.rbusy), 64'd0);
    checkOutput("re_off_data", 64'(rf_bus.rdata[63:32]), 64'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0);
    checkOutput("x7_cleared", 64'(rf_bus.rbusy), 64'd0);
    checkOutput("x7_stored", 64'(rf_bus.rdata[31:0]), 64'h55);

    // Set and clear of x9 in one cycle: set wins.
    applyStimulus(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 1'b0, 5'd0);
    checkOutput("x9_set_wins", 64'(rf_bus.rbusy), 64'b10);
    checkOutput("x9_data", 64'(rf_bus.rdata[63:32]), 64'h99);

    // Clear request wipes storage and scoreboard; clr_req inside CLEAR is ignored.
    applyStimulus(2'b01, 5'd4, 32'hAB, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd12);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd12, 1'b0, 5'd0);
    checkOutput("x4_before", 64'(rf_bus.rdata[31:0]), 64'hAB);
    checkOutput("x12_busy", 64'(rf_bus.rbusy), 64'b10);
    rf_bus.clr_req = 1'b1;
    tick();
    rf_bus.clr_req = 1'b0;
    checkOutput("clr_init_low", 64'(rf_bus.init_done), 64'd0);
    countSweep(1'b1, n);
    checkOutput("clr_len", 64'(n), 64'd32);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd12, 1'b0, 5'd0);
    checkOutput("x4_after", 64'(rf_bus.rdata[31:0]), 64'd0);
    checkOutput("busy_after_clr", 64'(rf_bus.rbusy), 64'd0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9, 1'b0, 5'd0);
    checkOutput("x9_busy_after_clr", 64'(rf_bus.rbusy), 64'd0);

    // Reset in the middle of a sweep restarts it from the beginning.
    rf_bus.clr_req = 1'b1;
    tick();
    rf_bus.clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midclr_rst", 64'(rf_bus.init_done), 64'd0);
    #1;
    rst_n = 1'b1;
    countSweep(1'b0, n);
    checkOutput("rst_restart_len", 64'(n), 64'd32);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
